// File: rtl/stream_arb2.sv
// Packet-granular round-robin arbiter: two upstream streams share one downstream stage.
// Optional watchdog abort on stalled packets is enabled by defining STREAM_ARB2_TIMEOUT_EN.
module stream_arb2 #(
    parameter int W    = 32,
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    uc0_d0,
    input  logic [3:0]      uc0_mflags,
    output logic [1:0]      cu0_sflags,
    input  logic [W-1:0]    uc1_d0,
    input  logic [3:0]      uc1_mflags,
    output logic [1:0]      cu1_sflags,
    output logic [W-1:0]    cd_d0,
    output logic [3:0]      cd_mflags,
    input  logic [1:0]      dc_sflags,
    output logic [1:0]      gnt,
    input  logic [TO_W-1:0] to_max,
    input  logic            clr_err,
    output logic            err_orphan,
    output logic            err_to
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   orphan_q, orphan_d;
    logic   orphanSet;
    logic   dcBsy, dcAbt;
    logic   req0, req1;
    logic   xfer;
    logic   toFire;
    logic   unusedAgain;

    assign dcBsy       = dc_sflags[0];
    assign dcAbt       = dc_sflags[1];
    assign req0        = uc0_mflags[0] & uc0_mflags[2];
    assign req1        = uc1_mflags[0] & uc1_mflags[2];
    assign unusedAgain = uc0_mflags[3] ^ uc1_mflags[3];

    // A beat moves on the granted port whenever it is valid and downstream is not busy
    always_comb begin
        xfer = 1'b0;
        case (state_q)
            LOCK0:   xfer = uc0_mflags[0] & ~dcBsy;
            LOCK1:   xfer = uc1_mflags[0] & ~dcBsy;
            default: xfer = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        orphanSet  = 1'b0;
        gnt        = 2'b00;
        cd_d0      = '0;
        cd_mflags  = {dcBsy, 3'b000};
        cu0_sflags = 2'b01;
        cu1_sflags = 2'b01;
        case (state_q)
            IDLE: begin
                // Non-first beats are swallowed so an orphaned tail cannot wedge its source
                if (uc0_mflags[0] && !uc0_mflags[2]) begin
                    cu0_sflags = 2'b00;
                    orphanSet  = 1'b1;
                end
                if (uc1_mflags[0] && !uc1_mflags[2]) begin
                    cu1_sflags = 2'b00;
                    orphanSet  = 1'b1;
                end
                if (req0 && req1) begin
                    state_d = ptr_q ? LOCK1 : LOCK0;
                end else if (req0) begin
                    state_d = LOCK0;
                end else if (req1) begin
                    state_d = LOCK1;
                end
            end
            LOCK0: begin
                gnt        = 2'b01;
                cd_d0      = uc0_d0;
                cd_mflags  = {dcBsy, uc0_mflags[2:0]};
                cu0_sflags = {dcAbt | toFire, dcBsy};
                if (dcAbt || toFire || (xfer && uc0_mflags[1])) begin
                    state_d = IDLE;
                    ptr_d   = 1'b1;
                end
            end
            LOCK1: begin
                gnt        = 2'b10;
                cd_d0      = uc1_d0;
                cd_mflags  = {dcBsy, uc1_mflags[2:0]};
                cu1_sflags = {dcAbt | toFire, dcBsy};
                if (dcAbt || toFire || (xfer && uc1_mflags[1])) begin
                    state_d = IDLE;
                    ptr_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign orphan_d   = orphanSet | (orphan_q & ~clr_err);
    assign err_orphan = orphan_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            orphan_q <= orphan_d;
        end
    end

`ifdef STREAM_ARB2_TIMEOUT_EN
    logic [TO_W-1:0] toCnt_q, toCnt_d, toInc;
    logic            errTo_q, errTo_d;
    logic            locked;

    assign locked = (state_q != IDLE);

    // Saturating stall counter; fires on the cycle the incremented count reaches the limit
    always_comb begin
        toInc   = (&toCnt_q) ? toCnt_q : toCnt_q + TO_W'(1);
        toFire  = locked & ~xfer & (to_max != '0) & (toInc >= to_max);
        toCnt_d = (!locked || xfer || toFire) ? '0 : toInc;
        errTo_d = toFire | (errTo_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toCnt_q <= '0;
            errTo_q <= 1'b0;
        end else begin
            toCnt_q <= toCnt_d;
            errTo_q <= errTo_d;
        end
    end

    assign err_to = errTo_q;
`else
    logic unusedToMax;

    assign toFire      = 1'b0;
    assign err_to      = 1'b0;
    assign unusedToMax = ^to_max;
`endif

endmodule

// File: tb/tb_stream_arb2.sv
// Table-driven bench for stream_arb2 with hand sequences for reset mid-packet and watchdog.
module tb_stream_arb2;
    localparam int W    = 32;
    localparam int TO_W = 8;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] FST  = 4'b0101;
    localparam logic [3:0] MID  = 4'b0001;
    localparam logic [3:0] LST  = 4'b0011;
    localparam logic [3:0] SGL  = 4'b0111;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [W-1:0]    uc0_d0, uc1_d0, cd_d0;
    logic [3:0]      uc0_mflags, uc1_mflags, cd_mflags;
    logic [1:0]      cu0_sflags, cu1_sflags, dc_sflags, gnt;
    logic [TO_W-1:0] to_max;
    logic            clr_err, err_orphan, err_to;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [W-1:0] d0;
        logic [3:0]   m0;
        logic [W-1:0] d1;
        logic [3:0]   m1;
        logic [1:0]   dc;
        logic         clr;
        logic [1:0]   eGnt;
        logic [W-1:0] eCd;
        logic [3:0]   eCdm;
        logic [1:0]   eS0;
        logic [1:0]   eS1;
        logic         eOrph;
    } vec_t;

    vec_t vecs[$];

    stream_arb2 #(.W(W), .TO_W(TO_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uc0_d0     (uc0_d0),
        .uc0_mflags (uc0_mflags),
        .cu0_sflags (cu0_sflags),
        .uc1_d0     (uc1_d0),
        .uc1_mflags (uc1_mflags),
        .cu1_sflags (cu1_sflags),
        .cd_d0      (cd_d0),
        .cd_mflags  (cd_mflags),
        .dc_sflags  (dc_sflags),
        .gnt        (gnt),
        .to_max     (to_max),
        .clr_err    (clr_err),
        .err_orphan (err_orphan),
        .err_to     (err_to)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic addVec(input logic [W-1:0] d0, input logic [3:0] m0,
                          input logic [W-1:0] d1, input logic [3:0] m1,
                          input logic [1:0] dc, input logic clr,
                          input logic [1:0] eGnt, input logic [W-1:0] eCd, input logic [3:0] eCdm,
                          input logic [1:0] eS0, input logic [1:0] eS1, input logic eOrph);
        vec_t v;
        v.d0 = d0; v.m0 = m0; v.d1 = d1; v.m1 = m1; v.dc = dc; v.clr = clr;
        v.eGnt = eGnt; v.eCd = eCd; v.eCdm = eCdm; v.eS0 = eS0; v.eS1 = eS1; v.eOrph = eOrph;
        vecs.push_back(v);
    endtask

    task automatic addIdle(input logic clr, input logic eOrph);
        addVec(0, NONE, 0, NONE, 2'b00, clr, 2'b00, 0, 4'b0000, 2'b01, 2'b01, eOrph);
    endtask

    task automatic applyStimulus(input vec_t v);
        uc0_d0     = v.d0;
        uc0_mflags = v.m0;
        uc1_d0     = v.d1;
        uc1_mflags = v.m1;
        dc_sflags  = v.dc;
        clr_err    = v.clr;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("row%0d gnt", idx), W'(gnt), W'(v.eGnt));
        checkVal($sformatf("row%0d cd_d0", idx), cd_d0, v.eCd);
        checkVal($sformatf("row%0d cd_mflags", idx), W'(cd_mflags), W'(v.eCdm));
        checkVal($sformatf("row%0d cu0_sflags", idx), W'(cu0_sflags), W'(v.eS0));
        checkVal($sformatf("row%0d cu1_sflags", idx), W'(cu1_sflags), W'(v.eS1));
        checkVal($sformatf("row%0d err_orphan", idx), W'(err_orphan), W'(v.eOrph));
        checkVal($sformatf("row%0d err_to", idx), W'(err_to), W'(0));
    endtask

    task automatic clearInputs();
        uc0_d0 = '0; uc0_mflags = NONE; uc1_d0 = '0; uc1_mflags = NONE;
        dc_sflags = 2'b00; clr_err = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        to_max = '0;
        clearInputs();

        // Reset state, then src0 three-beat packet
        addIdle(0, 0);
        addVec(1, FST, 0, NONE, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec(1, FST, 0, NONE, 2'b00, 0, 2'b01, 1, 4'b0101, 2'b00, 2'b01, 0);
        addVec(2, MID, 0, NONE, 2'b00, 0, 2'b01, 2, 4'b0001, 2'b00, 2'b01, 0);
        addVec(3, LST, 0, NONE, 2'b00, 0, 2'b01, 3, 4'b0011, 2'b00, 2'b01, 0);
        addIdle(0, 0);
        // src1 single-beat packet returns the pointer to src0
        addVec(0, NONE, 'hA, SGL, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec(0, NONE, 'hA, SGL, 2'b00, 0, 2'b10, 'hA, 4'b0111, 2'b01, 2'b00, 0);
        addIdle(0, 0);
        // Simultaneous requests alternate src0, src1, src0, src1
        addVec('h10, FST, 'h20, FST, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec('h10, FST, 'h20, FST, 2'b00, 0, 2'b01, 'h10, 4'b0101, 2'b00, 2'b01, 0);
        addVec('h11, LST, 'h20, FST, 2'b00, 0, 2'b01, 'h11, 4'b0011, 2'b00, 2'b01, 0);
        addVec(0, NONE, 'h20, FST, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec(0, NONE, 'h20, FST, 2'b00, 0, 2'b10, 'h20, 4'b0101, 2'b01, 2'b00, 0);
        addVec(0, NONE, 'h21, LST, 2'b00, 0, 2'b10, 'h21, 4'b0011, 2'b01, 2'b00, 0);
        addVec('h30, SGL, 'h40, FST, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec('h30, SGL, 'h40, FST, 2'b00, 0, 2'b01, 'h30, 4'b0111, 2'b00, 2'b01, 0);
        addVec(0, NONE, 'h40, FST, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec(0, NONE, 'h40, SGL, 2'b00, 0, 2'b10, 'h40, 4'b0111, 2'b01, 2'b00, 0);
        addIdle(0, 0);
        // Downstream busy for four cycles mid-packet
        addVec('h50, FST, 0, NONE, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec('h50, FST, 0, NONE, 2'b00, 0, 2'b01, 'h50, 4'b0101, 2'b00, 2'b01, 0);
        for (int i = 0; i < 4; i++)
            addVec('h51, MID, 0, NONE, 2'b01, 0, 2'b01, 'h51, 4'b1001, 2'b01, 2'b01, 0);
        addVec('h51, MID, 0, NONE, 2'b00, 0, 2'b01, 'h51, 4'b0001, 2'b00, 2'b01, 0);
        addVec('h52, LST, 0, NONE, 2'b00, 0, 2'b01, 'h52, 4'b0011, 2'b00, 2'b01, 0);
        // Downstream abort on beat 2 of src1, next grant goes to src0
        addVec(0, NONE, 'h60, FST, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec(0, NONE, 'h60, FST, 2'b00, 0, 2'b10, 'h60, 4'b0101, 2'b01, 2'b00, 0);
        addVec(0, NONE, 'h61, MID, 2'b10, 0, 2'b10, 'h61, 4'b0001, 2'b01, 2'b10, 0);
        addVec('h70, FST, 'h62, FST, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b01, 0);
        addVec('h70, SGL, 'h62, FST, 2'b00, 0, 2'b01, 'h70, 4'b0111, 2'b00, 2'b01, 0);
        addIdle(0, 0);
        // Orphan beat, clear, then set-wins-over-clear
        addVec(0, NONE, 'h99, MID, 2'b00, 0, 2'b00, 0, 4'b0000, 2'b01, 2'b00, 0);
        addIdle(0, 1);
        addIdle(1, 1);
        addIdle(0, 0);
        addVec(5, MID, 0, NONE, 2'b00, 1, 2'b00, 0, 4'b0000, 2'b00, 2'b01, 0);
        addIdle(0, 1);
        addIdle(1, 1);
        addIdle(0, 0);
        // Idle with downstream busy still reflects again
        addVec(0, NONE, 0, NONE, 2'b01, 0, 2'b00, 0, 4'b1000, 2'b01, 2'b01, 0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-packet drops the grant without waiting for a clock
        clearInputs();
        uc0_d0 = 'h77; uc0_mflags = FST;
        @(posedge clk); #1;
        @(negedge clk);
        checkVal("midpkt gnt locked", W'(gnt), W'(2'b01));
        checkVal("midpkt cd_vld before reset", W'(cd_mflags[0]), W'(1));
        #2 rst_n = 1'b0;
        #1;
        checkVal("midpkt gnt after reset", W'(gnt), W'(0));
        checkVal("midpkt cd_vld after reset", W'(cd_mflags[0]), W'(0));
        checkVal("midpkt cu0 after reset", W'(cu0_sflags), W'(2'b01));
        clearInputs();
        @(posedge clk); #1 rst_n = 1'b1;

`ifdef STREAM_ARB2_TIMEOUT_EN
        // Watchdog: src0 stalls after its first beat, abort on the fifth stalled cycle
        to_max = 8'd5;
        uc0_d0 = 'h88; uc0_mflags = FST;
        @(posedge clk); #1;
        @(negedge clk);
        checkVal("to first beat cu0", W'(cu0_sflags), W'(2'b00));
        @(posedge clk); #1;
        uc0_mflags = NONE;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checkVal($sformatf("to stall%0d cu0", i), W'(cu0_sflags), (i == 5) ? W'(2'b10) : W'(2'b00));
            checkVal($sformatf("to stall%0d err_to", i), W'(err_to), W'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkVal("to idle gnt", W'(gnt), W'(0));
        checkVal("to err_to set", W'(err_to), W'(1));
        to_max = '0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
